// File: rtl/divmul_pkg.sv
// Purpose: shared widths and FSM state type for the dividend reconstructor datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Ports: none.
package divmul_pkg;

    localparam int QW_DEF = 5;                // quotient / multiplier width
    localparam int DW_DEF = 2;                // divisor / multiplicand width
    localparam int RW_DEF = 5;                // remainder width
    localparam int PW_DEF = QW_DEF + DW_DEF;  // product / result width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } recon_state_t;

endpackage

// File: rtl/dividend_reconstructor_mul_step.sv
// Purpose: one radix-2 shift-add multiply step on {acc, mplr, mcand}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the results.
// Ports: acc/mplr/mcand current values in; acc_nxt/mplr_nxt/mcand_nxt step results out.
module mul_step
    import divmul_pkg::*;
#(
    parameter int QW = QW_DEF,
    parameter int PW = PW_DEF
) (
    input  logic [PW-1:0] acc,
    input  logic [QW-1:0] mplr,
    input  logic [PW-1:0] mcand,
    output logic [PW-1:0] acc_nxt,
    output logic [QW-1:0] mplr_nxt,
    output logic [PW-1:0] mcand_nxt
);

    always_comb begin
        // Add the aligned multiplicand only when the current multiplier LSB is set.
        acc_nxt   = mplr[0] ? (acc + mcand) : acc;
        mplr_nxt  = mplr >> 1;
        mcand_nxt = mcand << 1;
    end

endmodule

// File: rtl/dividend_reconstructor.sv
// Purpose: rebuilds dividend = q*d + rem by sequential radix-2 shift-add (unsigned).
// Latency: QW+1 cycles from the accept cycle to out_valid; fewer with RECON_EARLY_TERM_EN defined.
// Backpressure: in_ready low while BUSY/DONE; out_ready low holds DONE with dividend stable.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with q, d, rem;
//        out_valid/out_ready with dividend (registered, equals the accumulator).
// Config macro: RECON_EARLY_TERM_EN -- finish as soon as no multiplier bits remain.
module dividend_reconstructor
    import divmul_pkg::*;
#(
    parameter int QW = QW_DEF,
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [QW-1:0]      q,
    input  logic [DW-1:0]      d,
    input  logic [RW-1:0]      rem,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [QW+DW-1:0]   dividend
);

    localparam int PW = QW + DW;
    localparam int CW = $clog2(QW + 1);

    recon_state_t  state;
    recon_state_t  state_nxt;

    logic [PW-1:0] acc;
    logic [QW-1:0] mplr;
    logic [PW-1:0] mcand;
    logic [CW-1:0] count;

    logic [PW-1:0] acc_nxt;
    logic [QW-1:0] mplr_nxt;
    logic [PW-1:0] mcand_nxt;
    logic          last_step;

    mul_step #(
        .QW (QW),
        .PW (PW)
    ) u_step (
        .acc       (acc),
        .mplr      (mplr),
        .mcand     (mcand),
        .acc_nxt   (acc_nxt),
        .mplr_nxt  (mplr_nxt),
        .mcand_nxt (mcand_nxt)
    );

    // Final BUSY cycle: either all QW bits consumed, or (early-term build)
    // no set bits remain after this step's shift.
`ifdef RECON_EARLY_TERM_EN
    assign last_step = (count == CW'(QW - 1)) || (mplr_nxt == '0);
`else
    assign last_step = (count == CW'(QW - 1));
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Outputs depend on state only, so there is no input-to-output comb path.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath registers: loaded on accept, stepped in BUSY, frozen otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            mplr  <= '0;
            mcand <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= PW'(rem);
                        mplr  <= q;
                        mcand <= PW'(d);
                        count <= '0;
                    end
                end
                BUSY: begin
                    acc   <= acc_nxt;
                    mplr  <= mplr_nxt;
                    mcand <= mcand_nxt;
                    count <= count + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign dividend = acc;

endmodule

// File: tb/tb_dividend_reconstructor.sv
module tb_dividend_reconstructor;

    localparam int QW = 5;
    localparam int DW = 2;
    localparam int RW = 5;
    localparam int PW = QW + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [QW-1:0] q = '0;
    logic [DW-1:0] d = '0;
    logic [RW-1:0] rem = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] dividend;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dividend_reconstructor #(.QW(QW), .DW(DW), .RW(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .d         (d),
        .rem       (rem),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dividend  (dividend)
    );

    // Reference: plain arithmetic product plus remainder.
    function automatic int ref_result(input int qv, input int dv, input int rv);
        return qv * dv + rv;
    endfunction

    // Reference latency: cycles from the accept cycle (counted as 1) up to out_valid.
    function automatic int ref_latency(input int qv);
`ifdef RECON_EARLY_TERM_EN
        int msb;
        msb = -1;
        for (int i = 0; i < QW; i++) if (((qv >> i) & 1) == 1) msb = i;
        return (msb < 0) ? 2 : msb + 2;
`else
        return QW + 1;
`endif
    endfunction

    // Drives one operation with out_ready high; reports result, latency and timeout.
    task automatic run_op(input int qi, input int di, input int ri,
                          output int res, output int lat, output bit tmo);
        int n;
        tmo = 1'b0;
        lat = 0;
        res = 0;
        @(negedge clk);
        q = QW'(qi); d = DW'(di); rem = RW'(ri);
        in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            tmo = 1'b1;
            in_valid = 1'b0;
            return;
        end
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            n++;
        end while (out_valid !== 1'b1 && n < 50);
        if (out_valid !== 1'b1) tmo = 1'b1;
        lat = n;
        res = int'(dividend);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        q = 5'd7; d = 2'd3; rem = 5'd9;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, out_valid, dividend} !== {1'b1, 1'b0, 7'd0})
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b dividend=%0d want 1 0 0",
                     in_ready, out_valid, dividend);
        else passed++;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL reset_release_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_directed();
        int tq[5];
        int td[5];
        int tr[5];
        int te[5];
        int cnt;
        int res, lat;
        bit tmo;
        tq = '{6, 31, 0, 17, 1};
        td = '{2, 3, 3, 0, 3};
        tr = '{1, 31, 4, 0, 0};
        te = '{13, 124, 4, 0, 3};
        cnt = 4;
`ifdef RECON_EARLY_TERM_EN
        cnt = 5;
`endif
        for (int i = 0; i < cnt; i++) begin
            run_op(tq[i], td[i], tr[i], res, lat, tmo);
            total++;
            if (tmo || res != te[i])
                $display("FAIL directed_result[%0d]: got %0d (timeout=%0b) want %0d", i, res, tmo, te[i]);
            else passed++;
            total++;
            if (lat != ref_latency(tq[i]))
                $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, ref_latency(tq[i]));
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int n;
        int e;
        e = ref_result(21, 3, 17);
        @(negedge clk);
        q = 5'd21; d = 2'd3; rem = 5'd17; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        n = 0;
        do begin
            @(negedge clk);
            // Garbage offered while busy must be ignored.
            q = 5'd30; d = 2'd2; rem = 5'd5; in_valid = 1'b1;
            n++;
        end while (out_valid !== 1'b1 && n < 50);
        total++;
        if (out_valid !== 1'b1)
            $display("FAIL bp_reach_done: out_valid=%b want 1", out_valid);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, dividend} !== {1'b1, 1'b0, 7'(e)})
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b dividend=%0d want 1 0 %0d",
                         i, out_valid, in_ready, dividend, e);
            else passed++;
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_reset_mid_busy();
        bit seen;
        @(negedge clk);
        q = 5'd16; d = 2'd3; rem = 5'd2; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);          // first BUSY cycle
        in_valid = 1'b0;
        @(negedge clk);          // second BUSY cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({out_valid, in_ready, dividend} !== {1'b0, 1'b1, 7'd0})
            $display("FAIL rst_mid_busy: out_valid=%b in_ready=%b dividend=%0d want 0 1 0",
                     out_valid, in_ready, dividend);
        else passed++;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen)
            $display("FAIL rst_mid_busy_no_result: out_valid rose after abort, want none");
        else passed++;
    endtask

    task automatic test_back_to_back();
        localparam int N = 24;
        int expq[$];
        int sent, got, cyc;
        int e;
        bit reload;
        sent = 0; got = 0; cyc = 0; reload = 1'b1;
        while (got < N && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (reload) begin
                if (sent < N) begin
                    q = QW'($urandom); d = DW'($urandom); rem = RW'($urandom);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                reload = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid === 1'b1 && out_ready) begin
                e = (expq.size() > 0) ? expq.pop_front() : -1;
                total++;
                if (dividend !== 7'(e) || e < 0)
                    $display("FAIL b2b_result[%0d]: got %0d want %0d", got, dividend, e);
                else passed++;
                got++;
            end
            if (in_valid && in_ready === 1'b1) begin
                expq.push_back(ref_result(int'(q), int'(d), int'(rem)));
                sent++;
                reload = 1'b1;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != N || sent != N || expq.size() != 0)
            $display("FAIL b2b_count: sent=%0d got=%0d pending=%0d want %0d %0d 0",
                     sent, got, expq.size(), N, N);
        else passed++;
    endtask

    task automatic test_random();
        int qi, di, ri, res, lat;
        bit tmo;
        for (int i = 0; i < 150; i++) begin
            qi = int'($urandom_range(0, 31));
            di = int'($urandom_range(0, 3));
            ri = int'($urandom_range(0, 31));
            run_op(qi, di, ri, res, lat, tmo);
            total++;
            if (tmo || res != ref_result(qi, di, ri) || lat != ref_latency(qi))
                $display("FAIL random[%0d] q=%0d d=%0d rem=%0d: got %0d lat %0d want %0d lat %0d",
                         i, qi, di, ri, res, lat, ref_result(qi, di, ri), ref_latency(qi));
            else passed++;
        end
    endtask

    task automatic test_exhaustive();
        int res, lat;
        bit tmo;
        for (int qi = 0; qi < 32; qi++)
            for (int di = 0; di < 4; di++)
                for (int ri = 0; ri < 32; ri++) begin
                    run_op(qi, di, ri, res, lat, tmo);
                    total++;
                    if (tmo || res != ref_result(qi, di, ri))
                        $display("FAIL exhaustive q=%0d d=%0d rem=%0d: got %0d want %0d",
                                 qi, di, ri, res, ref_result(qi, di, ri));
                    else passed++;
                end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        test_random();
        test_exhaustive();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1);
    end

endmodule
